// File: rtl/fp_class_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_class_pkg
//  Purpose  : Shared constants for the streaming IEEE-754 classifier.
//             Defines the number of classes, the bit position of each
//             class in the one-hot code, and the counter-select index type.
//  Revision : 1.0  initial release
// ============================================================================
package fp_class_pkg;

    localparam int NCLASS    = 10;

    // One-hot bit positions. Signed classes run from most negative to most
    // positive so the code reads like a number line; NaNs ignore the sign.
    localparam int CLS_NINF  = 0;
    localparam int CLS_NNORM = 1;
    localparam int CLS_NSUB  = 2;
    localparam int CLS_NZERO = 3;
    localparam int CLS_PZERO = 4;
    localparam int CLS_PSUB  = 5;
    localparam int CLS_PNORM = 6;
    localparam int CLS_PINF  = 7;
    localparam int CLS_SNAN  = 8;
    localparam int CLS_QNAN  = 9;

    // Counter read index (covers 0..15; indices >= NCLASS read as zero).
    typedef logic [3:0] cls_idx_t;

endpackage
`default_nettype wire

// File: rtl/fp_class_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_class_pipe_if
//  Purpose  : Bundles the operand stream, the classified result stream and
//             the counter access signals of fp_class_pipe.
//  Ports    : in_valid/in_ready/in_f      operand input stream
//             out_valid/out_ready/out_f/out_class  classified output stream
//             cnt_clr/cnt_sel/cnt_value   counter clear and read-back
//  Modports : master - operand source / result sink / status reader
//             slave  - the classifier pipeline
//  Revision : 1.0  initial release
// ============================================================================
interface fp_class_pipe_if #(
    parameter int NEXP = 5,
    parameter int NSIG = 10,
    parameter int CNTW = 16
);
    import fp_class_pkg::*;

    localparam int W = NEXP + NSIG + 1;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_f;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_f;
    logic [NCLASS-1:0] out_class;
    logic              cnt_clr;
    cls_idx_t          cnt_sel;
    logic [CNTW-1:0]   cnt_value;

    modport master (
        output in_valid, in_f, out_ready, cnt_clr, cnt_sel,
        input  in_ready, out_valid, out_f, out_class, cnt_value
    );

    modport slave (
        input  in_valid, in_f, out_ready, cnt_clr, cnt_sel,
        output in_ready, out_valid, out_f, out_class, cnt_value
    );

endinterface
`default_nettype wire

// File: rtl/fp_class_comb.sv
`default_nettype none
// ============================================================================
//  Module   : fp_class_comb
//  Purpose  : Purely combinational IEEE-754 classifier for any exponent and
//             significand width. Produces a 10-bit one-hot class code.
//  Ports    : f    in   NEXP+NSIG+1  operand {sign, exp, sig}
//             cls  out  NCLASS       one-hot class
//  Revision : 1.0  initial release
// ============================================================================
module fp_class_comb
    import fp_class_pkg::*;
#(
    parameter int NEXP = 5,
    parameter int NSIG = 10
) (
    input  logic [NEXP+NSIG:0] f,
    output logic [NCLASS-1:0]  cls
);

    logic            w_sign;
    logic [NEXP-1:0] w_exp;
    logic [NSIG-1:0] w_sig;
    logic            w_exp_ones;
    logic            w_exp_zero;
    logic            w_sig_zero;
    logic            w_quiet;

    assign w_sign     = f[NEXP+NSIG];
    assign w_exp      = f[NEXP+NSIG-1:NSIG];
    assign w_sig      = f[NSIG-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_sig_zero = ~|w_sig;
    assign w_quiet    = w_sig[NSIG-1];

    // Priority chain keeps the result one-hot by construction.
    always_comb begin
        cls = '0;
        if (w_exp_ones && !w_sig_zero) begin
            if (w_quiet) cls[CLS_QNAN] = 1'b1;
            else         cls[CLS_SNAN] = 1'b1;
        end else if (w_exp_ones) begin
            cls[w_sign ? CLS_NINF : CLS_PINF] = 1'b1;
        end else if (w_exp_zero && w_sig_zero) begin
            cls[w_sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
        end else if (w_exp_zero) begin
            cls[w_sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
        end else begin
            cls[w_sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_class_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_class_pipe
//  Purpose  : Two-stage valid/ready pipeline that classifies IEEE-754
//             operands into a 10-class one-hot code and keeps a saturating
//             event counter per class with registered read-back.
//  Ports    : clk  in  clock, rising edge
//             rst  in  synchronous active-high reset
//             bus  slave modport of fp_class_pipe_if (streams + counters)
//  Revision : 1.0  initial release
// ============================================================================
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int NEXP = 5,
    parameter int NSIG = 10,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    fp_class_pipe_if.slave    bus
);

    localparam int W = NEXP + NSIG + 1;

    // Pipeline state
    logic                         s1_valid_q, s1_valid_d;
    logic [W-1:0]                 s1_f_q,     s1_f_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [W-1:0]                 s2_f_q,     s2_f_d;
    logic [NCLASS-1:0]            s2_class_q, s2_class_d;

    // Counters and read-back
    logic [NCLASS-1:0][CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]              cnt_value_q, cnt_value_d;

    logic                         w_s2_adv;
    logic                         w_in_ready;
    logic                         w_in_hs;
    logic                         w_out_hs;
    logic [NCLASS-1:0]            w_s1_class;

    // Classification sits between S1 and S2 so the S2 register captures it.
    fp_class_comb #(
        .NEXP (NEXP),
        .NSIG (NSIG)
    ) u_comb (
        .f   (s1_f_q),
        .cls (w_s1_class)
    );

    assign w_s2_adv   = ~s2_valid_q | bus.out_ready;
    assign w_in_ready = ~s1_valid_q | w_s2_adv;
    assign w_in_hs    = bus.in_valid & w_in_ready;
    assign w_out_hs   = s2_valid_q & bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_f_d     = s1_f_q;
        s2_valid_d = s2_valid_q;
        s2_f_d     = s2_f_q;
        s2_class_d = s2_class_q;

        // S2 takes whatever S1 holds whenever it may advance; when S1 is
        // empty this simply retires the word just handed off downstream.
        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_f_d     = s1_f_q;
                s2_class_d = w_s1_class;
            end
        end

        // A new accept refills S1; otherwise S1 empties if it moved on.
        if (w_in_hs) begin
            s1_valid_d = 1'b1;
            s1_f_d     = bus.in_f;
        end else if (s1_valid_q && w_s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Clear has priority over a coincident count event.
    for (genvar i = 0; i < NCLASS; i++) begin : g_cnt
        logic w_sat;
        assign w_sat = (cnt_q[i] == {CNTW{1'b1}});
        always_comb begin
            cnt_d[i] = cnt_q[i];
            if (bus.cnt_clr) begin
                cnt_d[i] = '0;
            end else if (w_out_hs && s2_class_q[i] && !w_sat) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end
        end
    end

    // Read mux uses the pre-update counter value; out-of-range reads zero.
    always_comb begin
        cnt_value_d = '0;
        for (int i = 0; i < NCLASS; i++) begin
            if (bus.cnt_sel == cls_idx_t'(i)) begin
                cnt_value_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_f_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_f_q      <= '0;
            s2_class_q  <= '0;
            cnt_q       <= '0;
            cnt_value_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_f_q      <= s1_f_d;
            s2_valid_q  <= s2_valid_d;
            s2_f_q      <= s2_f_d;
            s2_class_q  <= s2_class_d;
            cnt_q       <= cnt_d;
            cnt_value_q <= cnt_value_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_f     = s2_f_q;
    assign bus.out_class = s2_class_q;
    assign bus.cnt_value = cnt_value_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_class_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_class_pipe
//  Purpose  : Self-checking bench for fp_class_pipe. Three instances:
//             binary16 with 16-bit counters, binary16 with 2-bit counters,
//             and binary32. Directed vector tables plus hand-written
//             sequences for backpressure, counter clear and mid-stream reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_class_pipe;
    import fp_class_pkg::*;

    typedef struct {
        logic [15:0] f;
        logic [9:0]  cls;
    } vec16_t;

    typedef struct {
        logic [31:0] f;
        logic [9:0]  cls;
    } vec32_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_class_pipe_if #(.NEXP(5), .NSIG(10), .CNTW(16)) d_if ();
    fp_class_pipe_if #(.NEXP(5), .NSIG(10), .CNTW(2))  c_if ();
    fp_class_pipe_if #(.NEXP(8), .NSIG(23), .CNTW(16)) w_if ();

    fp_class_pipe #(.NEXP(5), .NSIG(10), .CNTW(16)) u_d (.clk(clk), .rst(rst), .bus(d_if));
    fp_class_pipe #(.NEXP(5), .NSIG(10), .CNTW(2))  u_c (.clk(clk), .rst(rst), .bus(c_if));
    fp_class_pipe #(.NEXP(8), .NSIG(23), .CNTW(16)) u_w (.clk(clk), .rst(rst), .bus(w_if));

    int          n_tests = 0;
    int          n_fail  = 0;

    vec16_t      v16 [10];
    vec32_t      v32 [4];
    vec16_t      exp_q [$];
    vec16_t      mon_e;
    vec16_t      mon_n;
    logic [9:0]  drv_cls = '0;
    logic        mon_en  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_f = '0;
    logic [9:0]  prev_cls = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the binary16 / 16-bit-counter instance: records every
    // accepted operand with its table class, checks every delivered word in
    // order, and checks that a stalled output holds still.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(d_if.out_valid), 64'd1);
                chk("hold_f",     64'(d_if.out_f),     64'(prev_f));
                chk("hold_class", 64'(d_if.out_class), 64'(prev_cls));
            end
            if (d_if.out_valid && d_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stray_word", 64'(d_if.out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_f",     64'(d_if.out_f),     64'(mon_e.f));
                    chk("out_class", 64'(d_if.out_class), 64'(mon_e.cls));
                end
            end
            if (d_if.in_valid && d_if.in_ready) begin
                mon_n.f   = d_if.in_f;
                mon_n.cls = drv_cls;
                exp_q.push_back(mon_n);
            end
        end
        prev_stall <= mon_en && d_if.out_valid && !d_if.out_ready;
        prev_f     <= d_if.out_f;
        prev_cls   <= d_if.out_class;
    end

    task automatic read_cnt(input int sel, input logic [15:0] req, input string name);
        d_if.cnt_sel = 4'(sel);
        tick();
        chk(name, 64'(d_if.cnt_value), 64'(req));
    endtask

    initial begin
        int idx;
        int guard;

        v16[0] = '{16'hFC00, 10'h001};
        v16[1] = '{16'hBC00, 10'h002};
        v16[2] = '{16'h8001, 10'h004};
        v16[3] = '{16'h8000, 10'h008};
        v16[4] = '{16'h0000, 10'h010};
        v16[5] = '{16'h0001, 10'h020};
        v16[6] = '{16'h3C00, 10'h040};
        v16[7] = '{16'h7C00, 10'h080};
        v16[8] = '{16'h7D00, 10'h100};
        v16[9] = '{16'h7E00, 10'h200};

        v32[0] = '{32'h7FC00000, 10'h200};
        v32[1] = '{32'hFF800001, 10'h100};
        v32[2] = '{32'h80000000, 10'h008};
        v32[3] = '{32'h00800000, 10'h040};

        d_if.in_valid = 0; d_if.in_f = '0; d_if.out_ready = 0; d_if.cnt_clr = 0; d_if.cnt_sel = '0;
        c_if.in_valid = 0; c_if.in_f = '0; c_if.out_ready = 0; c_if.cnt_clr = 0; c_if.cnt_sel = '0;
        w_if.in_valid = 0; w_if.in_f = '0; w_if.out_ready = 0; w_if.cnt_clr = 0; w_if.cnt_sel = '0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(d_if.out_valid), 64'd0);
        chk("rst_in_ready",  64'(d_if.in_ready),  64'd1);
        chk("rst_out_class", 64'(d_if.out_class), 64'd0);
        chk("rst_out_f",     64'(d_if.out_f),     64'd0);
        chk("rst_cnt_value", 64'(d_if.cnt_value), 64'd0);
        mon_en = 1'b1;

        // ---------------- 1: full-rate stream of all ten classes ----------
        d_if.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_if.in_valid = 1'b1;
            d_if.in_f     = v16[i].f;
            drv_cls       = v16[i].cls;
            @(negedge clk);
            chk("t1_in_ready", 64'(d_if.in_ready), 64'd1);
            chk("t1_latency",  64'(d_if.out_valid), 64'(i >= 2));
            tick();
        end
        d_if.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t1_drain_valid", 64'(d_if.out_valid), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("t1_idle_valid", 64'(d_if.out_valid), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        for (int k = 0; k < 10; k++) read_cnt(k, 16'd1, "t1_cnt");
        read_cnt(10, 16'd0, "t1_cnt_oob10");
        read_cnt(15, 16'd0, "t1_cnt_oob15");

        // ---------------- 2: backpressure ----------------
        d_if.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            d_if.in_valid = 1'b1;
            d_if.in_f     = v16[idx].f;
            drv_cls       = v16[idx].cls;
            @(negedge clk);
            chk("t2_in_ready", 64'(d_if.in_ready), 64'(c < 2));
            if (d_if.in_ready) idx++;
            tick();
        end
        chk("t2_stall_f",     64'(d_if.out_f),     64'(v16[0].f));
        chk("t2_stall_class", 64'(d_if.out_class), 64'(v16[0].cls));
        d_if.out_ready = 1'b1;
        guard = 0;
        while (idx < 10 && guard < 40) begin
            d_if.in_valid = 1'b1;
            d_if.in_f     = v16[idx].f;
            drv_cls       = v16[idx].cls;
            @(negedge clk);
            if (d_if.in_ready) idx++;
            tick();
            guard++;
        end
        chk("t2_all_sent", 64'(idx), 64'd10);
        d_if.in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || d_if.out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        read_cnt(6, 16'd2, "t2_cnt6");
        read_cnt(9, 16'd2, "t2_cnt9");
        read_cnt(7, 16'd2, "t2_cnt7");

        // ---------------- 4: clear coincident with a handshake ----------
        d_if.out_ready = 1'b0;
        d_if.in_valid  = 1'b1;
        d_if.in_f      = 16'h7C00;
        drv_cls        = 10'h080;
        tick();
        d_if.in_valid  = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_word_waiting", 64'(d_if.out_valid), 64'd1);
        tick();
        d_if.out_ready = 1'b1;
        d_if.cnt_clr   = 1'b1;
        tick();
        d_if.cnt_clr   = 1'b0;
        chk("t4_consumed", 64'(d_if.out_valid), 64'd0);
        read_cnt(7, 16'd0, "t4_cnt7_cleared");
        read_cnt(6, 16'd0, "t4_cnt6_cleared");
        d_if.in_valid = 1'b1;
        d_if.in_f     = 16'h7C00;
        drv_cls       = 10'h080;
        tick();
        d_if.in_valid = 1'b0;
        tick();
        tick();
        read_cnt(7, 16'd1, "t4_cnt7_after");

        // ---------------- 5: reset with both stages full ----------------
        d_if.out_ready = 1'b0;
        d_if.in_valid  = 1'b1;
        d_if.in_f      = v16[6].f;
        drv_cls        = v16[6].cls;
        tick();
        d_if.in_f      = v16[8].f;
        drv_cls        = v16[8].cls;
        tick();
        d_if.in_valid  = 1'b0;
        @(negedge clk);
        chk("t5_full_in_ready", 64'(d_if.in_ready), 64'd0);
        tick();
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        exp_q.delete();
        chk("t5_out_valid", 64'(d_if.out_valid), 64'd0);
        chk("t5_in_ready",  64'(d_if.in_ready),  64'd1);
        chk("t5_out_class", 64'(d_if.out_class), 64'd0);
        chk("t5_cnt_value", 64'(d_if.cnt_value), 64'd0);
        d_if.out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_stale", 64'(d_if.out_valid), 64'd0);
            tick();
        end
        for (int k = 0; k < 10; k++) read_cnt(k, 16'd0, "t5_cnt_zero");

        // ---------------- 3: saturation with 2-bit counters ----------------
        c_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_if.in_valid = 1'b1;
            c_if.in_f     = 16'h3C00;
            tick();
        end
        c_if.in_valid = 1'b0;
        tick();
        tick();
        tick();
        c_if.cnt_sel = 4'd6;
        tick();
        chk("t3_sat_cnt6", 64'(c_if.cnt_value), 64'd3);
        c_if.cnt_sel = 4'd12;
        tick();
        chk("t3_sel12", 64'(c_if.cnt_value), 64'd0);
        c_if.cnt_sel = 4'd5;
        tick();
        chk("t3_cnt5", 64'(c_if.cnt_value), 64'd0);

        // ---------------- 6: binary32 ----------------
        w_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                w_if.in_valid = 1'b1;
                w_if.in_f     = v32[i].f;
            end else begin
                w_if.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t6_valid", 64'(w_if.out_valid), 64'(i >= 2));
            if (i >= 2) begin
                chk("t6_class", 64'(w_if.out_class), 64'(v32[i-2].cls));
                chk("t6_f",     64'(w_if.out_f),     64'(v32[i-2].f));
            end
            tick();
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
